// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin mux-select arbiter.
// Optional timeout/preemption build: define MUX4_ARB_TIMEOUT_EN.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    idx_to_onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant/select bundle between the four requesters and the arbiter.
// Requesters use the master modport, the arbiter uses the slave modport.
interface mux4_rr_arbiter_if;
  import mux4_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               out_valid;
  logic               preempt;

  modport master (
    output req,
    input  gnt,
    input  sel,
    input  out_valid,
    input  preempt
  );

  modport slave (
    input  req,
    output gnt,
    output sel,
    output out_valid,
    output preempt
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first set request in order ptr+1, ptr+2, ptr+3, ptr.
module mux4_rr_arbiter_rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // rot[0] is the requester just after ptr, rot[NUM_REQ-1] is ptr itself.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      localparam logic [SEL_W-1:0] OFS = SEL_W'(gi + 1);
      assign rot[gi] = req[ptr + OFS];
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
      end
    end
  end

  assign any = |req;
  assign idx = ptr + SEL_W'(1) + off;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the shared 4:1 mux select, with a registered turnaround gap.
// Define MUX4_ARB_TIMEOUT_EN to enable the MAX_GRANT timeout with preemption.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_GRANT   = 8
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  mux4_rr_arbiter_if.slave  arb
);

  localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES + 1) : 1;

  arb_state_t         state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [SEL_W-1:0]   sel_reg;
  logic               out_valid_reg;
  logic [SEL_W-1:0]   ptr_reg;
  logic [TURN_W-1:0]  turn_cnt_reg;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;

  mux4_rr_arbiter_rr_pick4 u_rr_pick4 (
    .req (arb.req),
    .ptr (ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam int GCNT_W = $clog2(MAX_GRANT + 1);

  logic [GCNT_W-1:0] grant_cnt_reg;
  logic              preempt_reg;
`else
  // MAX_GRANT only has meaning in the timeout build; referenced so both builds share one parameter list.
  if (MAX_GRANT < 1) begin : g_max_grant_unused
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= '0;
      sel_reg       <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= SEL_W'(NUM_REQ - 1);
      turn_cnt_reg  <= '0;
`ifdef MUX4_ARB_TIMEOUT_EN
      grant_cnt_reg <= '0;
      preempt_reg   <= 1'b0;
`endif
    end else begin
`ifdef MUX4_ARB_TIMEOUT_EN
      preempt_reg <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (pick_any) begin
            state_reg     <= ST_GRANT;
            gnt_reg       <= idx_to_onehot(pick_idx);
            sel_reg       <= pick_idx;
            out_valid_reg <= 1'b1;
            ptr_reg       <= pick_idx;
`ifdef MUX4_ARB_TIMEOUT_EN
            grant_cnt_reg <= GCNT_W'(1);
`endif
          end
        end

        ST_GRANT: begin
          if (!arb.req[sel_reg]) begin
            state_reg     <= ST_TURN;
            gnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            turn_cnt_reg  <= '0;
          end
`ifdef MUX4_ARB_TIMEOUT_EN
          // Forced release only when someone else is waiting; ptr already points at the owner.
          else if (grant_cnt_reg == GCNT_W'(MAX_GRANT) && (arb.req & ~gnt_reg) != '0) begin
            state_reg     <= ST_TURN;
            gnt_reg       <= '0;
            out_valid_reg <= 1'b0;
            turn_cnt_reg  <= '0;
            preempt_reg   <= 1'b1;
          end else if (grant_cnt_reg != GCNT_W'(MAX_GRANT)) begin
            grant_cnt_reg <= grant_cnt_reg + GCNT_W'(1);
          end
`endif
        end

        ST_TURN: begin
          if (turn_cnt_reg == TURN_W'(TURN_CYCLES - 1)) begin
            state_reg <= ST_IDLE;
          end else begin
            turn_cnt_reg <= turn_cnt_reg + TURN_W'(1);
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign arb.gnt       = gnt_reg;
  assign arb.sel       = sel_reg;
  assign arb.out_valid = out_valid_reg;
`ifdef MUX4_ARB_TIMEOUT_EN
  assign arb.preempt   = preempt_reg;
`else
  assign arb.preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter (TURN_CYCLES=1, MAX_GRANT=8); grant order via a scoreboard queue.
module tb_mux4_rr_arbiter;
  import mux4_rr_arbiter_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic resetn;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(
    .TURN_CYCLES (1),
    .MAX_GRANT   (8)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .arb      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic settle();
    bus.req = 4'b0000;
    repeat (4) tick();
  endtask

  // Waits for a non-zero grant; ok=0 if the budget expires.
  task automatic wait_grant(input int budget, output logic [3:0] g, output int cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    g = 4'b0000;
    for (int i = 0; i < budget; i++) begin
      tick();
      cycles++;
      if (bus.gnt !== 4'b0000) begin
        g = bus.gnt;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3:0] g, e;
    int cyc;
    bit ok;
    resetn = 1'b0;
    bus.req = 4'hF;
    tick();
    tick();
    checks++;
    if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=%b", bus.gnt, 4'b0000); end
    checks++;
    if (bus.sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++;
    if (bus.preempt !== 1'b0) begin failures++; $display("FAIL reset_preempt got=%b exp=0", bus.preempt); end
    exp_q.push_back(4'b0001);
    resetn = 1'b1;
    wait_grant(4, g, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_first_grant got=timeout exp=0001");
    end else begin
      e = exp_q.pop_front();
      $display("grant gnt=%b sel=%0d (after reset)", g, bus.sel);
      if (g !== e) begin failures++; $display("FAIL reset_first_grant got=%b exp=%b", g, e); end
      checks++;
      if (cyc != 1) begin failures++; $display("FAIL reset_first_latency got=%0d exp=1", cyc); end
    end
    settle();
  endtask

  task automatic test_single();
    logic [3:0] e;
    bus.req = 4'b0100;
    exp_q.push_back(4'b0100);
    tick();
    e = exp_q.pop_front();
    $display("grant gnt=%b sel=%0d (single)", bus.gnt, bus.sel);
    checks++;
    if (bus.gnt !== e) begin failures++; $display("FAIL single_gnt got=%b exp=%b", bus.gnt, e); end
    checks++;
    if (bus.sel !== 2'd2) begin failures++; $display("FAIL single_sel got=%0d exp=2", bus.sel); end
    checks++;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL single_out_valid got=%b exp=1", bus.out_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL single_hold got=%b exp=0100 cycle=%0d", bus.gnt, i); end
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_release got=%b/%b exp=0000/0", bus.gnt, bus.out_valid);
    end
    checks++;
    if (bus.sel !== 2'd2) begin failures++; $display("FAIL single_turn_sel got=%0d exp=2", bus.sel); end
    tick();
    checks++;
    if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL single_idle got=%b exp=0000", bus.gnt); end
    settle();
  endtask

  // Owner 2 just released: order is 3,0,1,2, so 0101 goes to 0.
  task automatic test_rotation();
    logic [3:0] e;
    bus.req = 4'b0101;
    exp_q.push_back(4'b0001);
    tick();
    e = exp_q.pop_front();
    $display("grant gnt=%b sel=%0d (rotation)", bus.gnt, bus.sel);
    checks++;
    if (bus.gnt !== e) begin failures++; $display("FAIL rotation_gnt got=%b exp=%b", bus.gnt, e); end
    checks++;
    if (bus.sel !== 2'd0) begin failures++; $display("FAIL rotation_sel got=%0d exp=0", bus.sel); end
    settle();
  endtask

  task automatic test_drop_same_cycle();
    bus.req = 4'b0010;
    tick();
    $display("grant gnt=%b sel=%0d (drop same cycle)", bus.gnt, bus.sel);
    checks++;
    if (bus.gnt !== 4'b0010) begin failures++; $display("FAIL drop_gnt got=%b exp=0010", bus.gnt); end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drop_one_cycle got=%b/%b exp=0000/0", bus.gnt, bus.out_valid);
    end
    settle();
  endtask

  task automatic test_fairness();
    logic [3:0] g, e;
    int cyc;
    bit ok;
    resetn = 1'b0;
    bus.req = 4'b0000;
    tick();
    resetn = 1'b1;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(8, g, cyc, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL fair_grant_%0d got=timeout", k);
        break;
      end
      e = exp_q.pop_front();
      $display("grant gnt=%b sel=%0d (fairness %0d, idle=%0d)", g, bus.sel, k, cyc);
      if (g !== e) begin failures++; $display("FAIL fair_order_%0d got=%b exp=%b", k, g, e); end
      if (k > 0) begin
        checks++;
        if (cyc != 2) begin failures++; $display("FAIL fair_gap_%0d got=%0d exp=2", k, cyc); end
      end
      tick();
      tick();
      checks++;
      if (bus.gnt !== g) begin failures++; $display("FAIL fair_hold_%0d got=%b exp=%b", k, bus.gnt, g); end
      bus.req = bus.req & ~g;
      tick();
      checks++;
      if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL fair_release_%0d got=%b exp=0000", k, bus.gnt); end
      bus.req = bus.req | g;
    end
    exp_q.delete();
    settle();
  endtask

  task automatic test_timeout();
    logic [3:0] e;
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    tick();
    e = exp_q.pop_front();
    $display("grant gnt=%b sel=%0d (timeout owner)", bus.gnt, bus.sel);
    checks++;
    if (bus.gnt !== e) begin failures++; $display("FAIL timeout_first got=%b exp=%b", bus.gnt, e); end
    tick();
    bus.req = 4'b1010;
`ifdef MUX4_ARB_TIMEOUT_EN
    for (int c = 3; c <= 8; c++) begin
      tick();
      checks++;
      if (bus.gnt !== 4'b0010 || bus.preempt !== 1'b0) begin
        failures++;
        $display("FAIL timeout_hold_c%0d got=%b/%b exp=0010/0", c, bus.gnt, bus.preempt);
      end
    end
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_preempt got=%b/%b exp=0000/1", bus.gnt, bus.preempt);
    end
    exp_q.push_back(4'b1000);
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.preempt !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse got=%b/%b exp=0000/0", bus.gnt, bus.preempt);
    end
    tick();
    e = exp_q.pop_front();
    $display("grant gnt=%b sel=%0d (after preempt)", bus.gnt, bus.sel);
    checks++;
    if (bus.gnt !== e || bus.sel !== 2'd3) begin
      failures++;
      $display("FAIL timeout_next got=%b/%0d exp=%b/3", bus.gnt, bus.sel, e);
    end
`else
    // Toggle another non-granted line too: it must not disturb the held grant.
    for (int c = 0; c < 110; c++) begin
      tick();
      bus.req[0] = ~bus.req[0];
      checks++;
      if (bus.gnt !== 4'b0010 || bus.preempt !== 1'b0 || bus.sel !== 2'd1) begin
        failures++;
        $display("FAIL timeout_hold_c%0d got=%b/%b/%0d exp=0010/0/1", c, bus.gnt, bus.preempt, bus.sel);
      end
    end
`endif
    settle();
  endtask

  task automatic test_midop_reset();
    logic [3:0] g, e;
    int cyc;
    bit ok;
`ifdef MUX4_ARB_TIMEOUT_EN
    exp_q.push_back(4'b0001);
`else
    exp_q.push_back(4'b0100);
`endif
    bus.req = 4'hF;
    wait_grant(4, g, cyc, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midop_grant got=timeout");
    end else begin
      e = exp_q.pop_front();
      $display("grant gnt=%b sel=%0d (before mid-op reset)", g, bus.sel);
      if (g !== e) begin failures++; $display("FAIL midop_grant got=%b exp=%b", g, e); end
    end
    tick();
    resetn = 1'b0;
    tick();
    checks++;
    if (bus.gnt !== 4'b0000 || bus.out_valid !== 1'b0 || bus.sel !== 2'd0) begin
      failures++;
      $display("FAIL midop_reset got=%b/%b/%0d exp=0000/0/0", bus.gnt, bus.out_valid, bus.sel);
    end
    resetn = 1'b1;
    exp_q.push_back(4'b0001);
    tick();
    e = exp_q.pop_front();
    $display("grant gnt=%b sel=%0d (after mid-op reset)", bus.gnt, bus.sel);
    checks++;
    if (bus.gnt !== e) begin failures++; $display("FAIL midop_regrant got=%b exp=%b", bus.gnt, e); end
    settle();
  endtask

  initial begin
    resetn = 1'b0;
    bus.req = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_drop_same_cycle();
    test_fairness();
    test_timeout();
    test_midop_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
